// File: rtl/flopr_pipe_pkg.sv
// flopr_pipe_pkg: shared datapath width and count-width helper for the flopr_pipe slice.
package flopr_pipe_pkg;
    localparam int DEFAULT_WIDTH = 8;
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/flopr_pipe_flopenr_n.sv
// flopenr_n: one pipeline stage, an enabled data register plus a clearable valid bit.
module flopenr_n
    import flopr_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    // Bubbles clear valid but keep the old payload so data only toggles on real items.
    always_comb begin
        valid_d = clr ? 1'b0 : (en ? in_valid : valid_q);
        data_d  = (en && !clr && in_valid) ? in_data : data_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/flopr_pipe.sv
// flopr_pipe: DEPTH-stage valid/ready register pipeline with flush, bubble collapsing
// and a synchronous active-low reset.
module flopr_pipe
    import flopr_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [count_w(DEPTH)-1:0] count
);
    localparam int CW = count_w(DEPTH);
    logic [DEPTH:0]   ready;
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic             take;
    // Ready ripples back from the output; an empty stage is always ready.
    always_comb begin
        ready[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) ready[k] = !valid[k] || ready[k+1];
    end
    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) count = count + CW'(valid[k]);
    end
    assign in_ready  = ready[0] && !flush;
    assign take      = in_valid && in_ready;
    assign out_valid = valid[DEPTH-1] && !flush;
    assign out_data  = data[DEPTH-1];
    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        if (i == 0) begin : g_src
            assign src_valid = take;
            assign src_data  = in_data;
        end else begin : g_src
            assign src_valid = valid[i-1];
            assign src_data  = data[i-1];
        end
        flopenr_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .en       (ready[i]),
            .clr      (flush),
            .in_valid (src_valid),
            .in_data  (src_data),
            .out_valid(valid[i]),
            .out_data (data[i])
        );
    end
endmodule

// File: tb/tb_flopr_pipe.sv
// tb_flopr_pipe: scenario tasks plus randomized traffic, checked against an item-queue model.
module tb_flopr_pipe;
    localparam int W = 8;
    localparam int D = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [1:0] count;
    int         n_cmp = 0, n_bad = 0, cyc = 0;
    logic [11:0] ev, obs;

    always #5 clk = ~clk;

    flopr_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count)
    );

    assign obs = {in_ready, out_valid, count, out_data};

    // Model: in-flight items in age order (front = oldest), each with its stage position.
    typedef struct {logic [7:0] d; int p;} item_t;
    typedef struct {logic [7:0] d; int c;} rec_t;
    item_t      q[$];
    item_t      nq[$];
    bit         mv[$];
    logic [7:0] last_d = RV;
    rec_t       got[$], acc[$];

    // An item advances if the slot ahead is free or its occupant advances too.
    function automatic void calc_moves();
        mv.delete();
        for (int k = 0; k < q.size(); k++)
            mv.push_back(k == 0 ? (q[0].p < D - 1 || out_ready == 1'b1)
                                : (q[k-1].p != q[k].p + 1 || mv[k-1]));
    endfunction

    function automatic logic [11:0] expect_vec();
        logic r0;
        calc_moves();
        r0 = (q.size() == 0) ? 1'b1 : (q[q.size()-1].p != 0 || mv[q.size()-1]);
        return {r0 && !flush, q.size() > 0 && q[0].p == D - 1 && !flush, 2'(q.size()), last_d};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            q.delete();
            last_d = RV;
        end else if (flush) begin
            q.delete();
        end else begin
            ev = expect_vec();
            nq.delete();
            foreach (q[k]) begin
                if (!mv[k]) nq.push_back(q[k]);
                else if (q[k].p < D - 1) begin
                    nq.push_back('{q[k].d, q[k].p + 1});
                    if (q[k].p + 1 == D - 1) last_d = q[k].d;
                end
            end
            if (in_valid && ev[11]) nq.push_back('{in_data, 0});
            q = nq;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) got.push_back('{out_data, cyc});
            if (in_valid && in_ready) acc.push_back('{in_data, cyc});
        end
    end

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 2'd0, RV}) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs, {1'b1, 1'b0, 2'd0, RV});
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ev = expect_vec();
            n_cmp++;
            if (obs !== ev) begin n_bad++; $display("FAIL reset_drain c%0d: got %h want %h", c, obs, ev); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stream();
        got.delete(); acc.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 5); in_data = 8'(c + 1);
            @(negedge clk);
            ev = expect_vec();
            n_cmp++;
            if (obs !== ev) begin n_bad++; $display("FAIL stream c%0d: got %h want %h", c, obs, ev); end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got.size() != 5 || acc.size() != 5) begin
            n_bad++; $display("FAIL stream_count: got %0d out %0d in, want 5/5", got.size(), acc.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (got[k].d !== 8'(k + 1) || got[k].c != acc[0].c + D + k) begin
                    n_bad++;
                    $display("FAIL stream_item%0d: got %h at +%0d want %h at +%0d", k, got[k].d, got[k].c - acc[0].c, 8'(k + 1), D + k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        got.delete();
        for (int c = 0; c < 13; c++) begin
            out_ready = (c >= 6);
            in_valid  = (c <= 6);
            in_data   = (c < 4) ? 8'h10 + 8'(c) : (c < 6 ? 8'($urandom) : 8'h13);
            @(negedge clk);
            ev = expect_vec();
            n_cmp++;
            if (obs !== ev) begin n_bad++; $display("FAIL backpressure c%0d: got %h want %h", c, obs, ev); end
            if (c == 3) begin
                n_cmp++;
                if ({count, in_ready} !== {2'd3, 1'b0}) begin
                    n_bad++; $display("FAIL bp_full: got count %0d in_ready %b want 3/0", count, in_ready);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got.size() != 4) begin
            n_bad++; $display("FAIL bp_drain_count: got %0d want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got[k].d !== 8'h10 + 8'(k)) begin
                    n_bad++; $display("FAIL bp_drain%0d: got %h want %h", k, got[k].d, 8'h10 + 8'(k));
                end
            end
        end
    endtask

    task automatic test_full_shift();
        got.delete();
        for (int c = 0; c < 13; c++) begin
            out_ready = (c >= 3);
            in_valid  = (c < 7);
            in_data   = 8'h20 + 8'(c);
            @(negedge clk);
            ev = expect_vec();
            n_cmp++;
            if (obs !== ev) begin n_bad++; $display("FAIL full_shift c%0d: got %h want %h", c, obs, ev); end
            if (c >= 3 && c < 7) begin
                n_cmp++;
                if (count !== 2'd3) begin n_bad++; $display("FAIL full_shift_count c%0d: got %0d want 3", c, count); end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got.size() != 7) begin
            n_bad++; $display("FAIL full_shift_total: got %0d want 7", got.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                n_cmp++;
                if (got[k].d !== 8'h20 + 8'(k)) begin
                    n_bad++; $display("FAIL full_shift_order%0d: got %h want %h", k, got[k].d, 8'h20 + 8'(k));
                end
            end
        end
    endtask

    task automatic test_flush();
        got.delete();
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 4);
            flush     = (c == 2);
            in_valid  = (c != 3 && c <= 4);
            in_data   = 8'h30 + 8'(c < 4 ? c : 3);
            @(negedge clk);
            ev = expect_vec();
            n_cmp++;
            if (obs !== ev) begin n_bad++; $display("FAIL flush c%0d: got %h want %h", c, obs, ev); end
            if (c == 2) begin
                n_cmp++;
                if ({count, in_ready, out_valid} !== {2'd2, 1'b0, 1'b0}) begin
                    n_bad++; $display("FAIL flush_cycle: got count %0d in_ready %b out_valid %b want 2/0/0", count, in_ready, out_valid);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (count !== 2'd0) begin n_bad++; $display("FAIL flush_after: got count %0d want 0", count); end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++;
        if (got.size() != 1 || got[0].d !== 8'h33) begin
            n_bad++; $display("FAIL flush_leak: got %0d items first %h want 1 item 33", got.size(), got.size() > 0 ? got[0].d : 8'h00);
        end
    endtask

    task automatic test_midreset();
        got.delete();
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 3);
            reset     = (c != 3);
            in_valid  = (c < 6);
            in_data   = 8'h40 + 8'(c);
            @(negedge clk);
            ev = expect_vec();
            n_cmp++;
            if (obs !== ev) begin n_bad++; $display("FAIL midreset c%0d: got %h want %h", c, obs, ev); end
            if (c == 3) begin
                n_cmp++;
                if (count !== 2'd3) begin n_bad++; $display("FAIL midreset_pre: got count %0d want 3", count); end
            end
            if (c == 4) begin
                n_cmp++;
                if ({count, out_data} !== {2'd0, RV}) begin
                    n_bad++; $display("FAIL midreset_post: got count %0d data %h want 0/%h", count, out_data, RV);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; reset = 1'b1;
        n_cmp++;
        if (got.size() != 2 || got[0].d !== 8'h44 || got[1].d !== 8'h45) begin
            n_bad++; $display("FAIL midreset_resume: got %0d items want 44,45", got.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit tail;
            tail      = (c >= 590);
            reset     = tail || ($urandom_range(49) != 0);
            flush     = !tail && ($urandom_range(19) == 0);
            in_valid  = !tail && ($urandom_range(9) < 7);
            out_ready = tail || ($urandom_range(9) < 6);
            in_data   = 8'($urandom);
            @(negedge clk);
            ev = expect_vec();
            n_cmp++;
            if (obs !== ev) begin n_bad++; $display("FAIL random c%0d: got %h want %h", c, obs, ev); end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (count !== 2'd0) begin n_bad++; $display("FAIL random_end: got count %0d want 0", count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_shift();
        test_flush();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
